digit_serial_adder: RTL and testbench
=====================================

# digit_serial_adder

Parametrised, multi-cycle successor to the 4-bit combinational binary adder. It adds or subtracts two WIDTH-bit operands DIGIT bits per clock, using a start/busy/done handshake. It sits in datapaths where a full-width carry chain is too slow or too large. With DIGIT = WIDTH it reduces to a registered single-cycle adder.

## Interface

Parameters:

- WIDTH, default 16: operand and result width in bits. Must be ≥ 2.
- DIGIT, default 4: bits processed per cycle. Must divide WIDTH exactly. N = WIDTH/DIGIT is the cycle count.

Ports:

- clk, input, 1: single clock. Every register updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: request a new operation. Sampled only when busy = 0.
- A, input, WIDTH: operand A. Latched on accepted start.
- B, input, WIDTH: operand B. Latched on accepted start.
- Cin, input, 1: carry-in (add mode) or borrow-in (sub mode). Latched on accepted start.
- sub, input, 1: 0 = A + B + Cin; 1 = A − B − Cin. Latched on accepted start.
- busy, output, 1: high while an operation is in progress.
- done, output, 1: one-cycle pulse; results are valid from this cycle.
- sum, output, WIDTH: result, registered.
- Cout, output, 1: carry out of the MSB. In sub mode, 1 = no borrow.
- overflow, output, 1: two's-complement signed overflow of the result.

## Operation

- FSM has two states, IDLE and RUN. Reset and power-up state is IDLE.
- **IDLE, start = 1:**
  - Latch A into an operand shift register.
  - Latch B into a second shift register, or ~B when sub = 1.
  - Set the carry register to Cin when sub = 0, or ~Cin when sub = 1.
  - Clear the digit counter; go to RUN; busy = 1.
- **RUN, each cycle:**
  - Add the low DIGIT bits of both shift registers plus the carry register.
  - Shift the DIGIT-bit digit result into a result shift register, filling LSB-first.
  - Update the carry register; shift the operands right by DIGIT; increment the counter.
- **Last digit (counter = N−1):**
  - Also capture the carry into bit WIDTH−1.
  - Load sum from the completed result and Cout from the final carry.
  - Compute overflow = carry into MSB XOR carry out of MSB.
  - Assert done for one cycle; return to IDLE; busy = 0.
- sum, Cout and overflow hold their last values until the next completion. They never show partial results.
- start while busy = 1 is ignored and is not queued.
- start in the done cycle is accepted, since busy = 0 there. This allows back-to-back operations with no idle gap.
- Inputs A, B, Cin and sub may change freely after the accept edge.
- Arithmetic is modulo 2^WIDTH. The sub-mode identity is A + ~B + ~Cin.

## Timing

- Reset (rst = 1 at an edge) sets state = IDLE, busy = 0, done = 0, sum = 0, Cout = 0, overflow = 0, and clears the internal counter, carry and shift registers. Reset has priority over start.
- Latency: start is accepted at edge E0; done = 1 and results are valid after edge E0 + N. Example: N = 4 gives done in the fourth cycle after accept.
- Throughput: one result per N cycles with back-to-back starts.
- busy rises after E0 and falls after E0 + N, in the same edge where done rises.
- Reset mid-RUN aborts the operation. No done is produced, and outputs go to their reset values at that edge.
- N = 1: done follows start by exactly one cycle; busy is high for that single cycle.

## Test plan

- WIDTH = 4, DIGIT = 1, sub = 0, legacy vectors. done must assert 4 cycles after each accept.
  - 0101 + 1010 + 0 → sum 1111, Cout 0.
  - 1101 + 1011 + 1 → sum 1001, Cout 1.
  - 0101 + 1110 + 0 → sum 0011, Cout 1.
  - 1111 + 1010 + 1 → sum 1010, Cout 1.
- WIDTH = 16, DIGIT = 4, add:
  - 0x7FFF + 0x0001, Cin = 0 → sum 0x8000, Cout 0, overflow 1. done 4 cycles after accept.
  - 0xFFFF + 0x0001 → sum 0x0000, Cout 1, overflow 0.
- WIDTH = 16, DIGIT = 4, sub:
  - 0x0005 − 0x0007, Cin = 0 → sum 0xFFFE, Cout 0, overflow 0.
  - 0x8000 − 0x0001 → sum 0x7FFF, Cout 1, overflow 1.
- Handshake:
  - Pulse start again 2 cycles after accept, with different operands → ignored; first result unchanged.
  - Pulse start in the done cycle → second operation accepted, second done exactly 4 cycles later.
- Reset mid-operation: assert rst 2 cycles into RUN → busy, done, sum, Cout and overflow = 0 next cycle; no done pulse. A subsequent start completes correctly.
- Randomised check, WIDTH = 16 with DIGIT ∈ {1, 2, 4, 8, 16}: 1000 random A, B, Cin, sub → sum, Cout and overflow match a reference model; latency = N.

Source files
------------

// File: rtl/digit_serial_adder_if.sv
// Handshake and operand/result bundle for digit_serial_adder.
// The master issues operations and the slave (the adder) returns results.
interface digit_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             Cout;
  logic             overflow;

  modport master (
    output start, A, B, Cin, sub,
    input  busy, done, sum, Cout, overflow
  );

  modport slave (
    input  start, A, B, Cin, sub,
    output busy, done, sum, Cout, overflow
  );
endinterface

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor that consumes DIGIT bits of a WIDTH-bit
// operation per clock behind a start/busy/done handshake.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic                 clk,
  input logic                 rst,
  digit_serial_adder_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;

  logic             accept, lastDigit, msbCarryIn;
  logic [DIGIT:0]   digitSum;
  logic [WIDTH-1:0] digitExt, resShift;

  assign accept     = (state_q == IDLE) && bus.start;
  assign lastDigit  = (cnt_q == CW'(N - 1));
  assign digitSum   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, carry_q};
  // Carry entering the top bit of this digit; only meaningful on the last one.
  assign msbCarryIn = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ digitSum[DIGIT-1];
  assign digitExt   = WIDTH'(digitSum[DIGIT-1:0]);
  assign resShift   = (res_q >> DIGIT) | (digitExt << (WIDTH - DIGIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (lastDigit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == RUN);
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (accept) begin
      // Subtraction is folded into A + ~B + ~Cin at load time.
      a_d     = bus.A;
      b_d     = bus.sub ? ~bus.B : bus.B;
      carry_d = bus.Cin ^ bus.sub;
      res_d   = '0;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> DIGIT;
      b_d     = b_q >> DIGIT;
      carry_d = digitSum[DIGIT];
      res_d   = resShift;
      cnt_d   = cnt_q + CW'(1);
      if (lastDigit) begin
        sum_d  = resShift;
        cout_d = digitSum[DIGIT];
        ovf_d  = msbCarryIn ^ digitSum[DIGIT];
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.Cout     = cout_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder: WIDTH=16 instances for every
// legal DIGIT plus a WIDTH=4, DIGIT=1 instance for the legacy vectors.
module tb_digit_serial_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] aIn, bIn;
  logic        cinIn, subIn;
  logic [5:0]  startV, doneV, busyV, coutV, ovfV;
  logic [15:0] sumArr [6];

  int checks   = 0;
  int failures = 0;

  // Instances 0..4: WIDTH=16 with DIGIT = 1,2,4,8,16.
  for (genvar g = 0; g < 5; g++) begin : gen16
    digit_serial_adder_if #(.WIDTH(16)) bus ();
    assign bus.start = startV[g];
    assign bus.A     = aIn;
    assign bus.B     = bIn;
    assign bus.Cin   = cinIn;
    assign bus.sub   = subIn;
    digit_serial_adder #(.WIDTH(16), .DIGIT(1 << g)) dut (
      .clk(clk), .rst(rst), .bus(bus)
    );
    assign doneV[g]  = bus.done;
    assign busyV[g]  = bus.busy;
    assign coutV[g]  = bus.Cout;
    assign ovfV[g]   = bus.overflow;
    assign sumArr[g] = bus.sum;
  end

  // Instance 5: the legacy 4-bit, one-bit-per-cycle configuration.
  digit_serial_adder_if #(.WIDTH(4)) bus4 ();
  assign bus4.start = startV[5];
  assign bus4.A     = aIn[3:0];
  assign bus4.B     = bIn[3:0];
  assign bus4.Cin   = cinIn;
  assign bus4.sub   = subIn;
  digit_serial_adder #(.WIDTH(4), .DIGIT(1)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );
  assign doneV[5]  = bus4.done;
  assign busyV[5]  = bus4.busy;
  assign coutV[5]  = bus4.Cout;
  assign ovfV[5]   = bus4.overflow;
  assign sumArr[5] = {12'h000, bus4.sum};

  typedef struct {
    int          inst;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] expSum;
    logic        expCout;
    logic        expOvf;
  } vec_t;

  function automatic int latencyOf(input int inst);
    return (inst == 5) ? 4 : (16 >> inst);
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                input logic cin, input logic sub,
                                output logic [15:0] s, output logic c,
                                output logic v);
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int ci = cin ? 1 : 0;
    int r, sr;
    if (!sub) begin
      r  = ua + ub + ci;
      sr = sa + sb + ci;
      c  = (r > 65535);
    end else begin
      r  = ua - ub - ci;
      sr = sa - sb - ci;
      c  = (r >= 0);
    end
    s = r[15:0];
    v = (sr > 32767) || (sr < -32768);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int inst, input logic [15:0] a,
                               input logic [15:0] b, input logic cin,
                               input logic sub);
    aIn          = a;
    bIn          = b;
    cinIn        = cin;
    subIn        = sub;
    startV[inst] = 1'b1;
  endtask

  task automatic waitAccept();
    @(posedge clk);
    #1;
    startV = '0;
  endtask

  task automatic waitDone(input int inst, output int lat);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (doneV[inst]) break;
    end
  endtask

  task automatic runOp(input int inst, input logic [15:0] a,
                       input logic [15:0] b, input logic cin,
                       input logic sub, output int lat);
    @(negedge clk);
    applyStimulus(inst, a, b, cin, sub);
    waitAccept();
    waitDone(inst, lat);
  endtask

  vec_t vecs [8];

  initial begin
    int          lat;
    logic [15:0] mSum;
    logic        mCout, mOvf;
    logic        sawDone;

    vecs[0] = '{5, 16'h0005, 16'h000A, 1'b0, 1'b0, 16'h000F, 1'b0, 1'b0};
    vecs[1] = '{5, 16'h000D, 16'h000B, 1'b1, 1'b0, 16'h0009, 1'b1, 1'b0};
    vecs[2] = '{5, 16'h0005, 16'h000E, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b0};
    vecs[3] = '{5, 16'h000F, 16'h000A, 1'b1, 1'b0, 16'h000A, 1'b1, 1'b0};
    vecs[4] = '{2, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{2, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[7] = '{2, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};

    rst    = 1'b1;
    startV = '0;
    aIn    = '0;
    bIn    = '0;
    cinIn  = 1'b0;
    subIn  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busyV), 32'h0);
    checkOutput("reset_done", 32'(doneV), 32'h0);
    checkOutput("reset_cout", 32'(coutV), 32'h0);
    checkOutput("reset_ovf", 32'(ovfV), 32'h0);
    checkOutput("reset_sum16", 32'(sumArr[2]), 32'h0);
    checkOutput("reset_sum4", 32'(sumArr[5]), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      runOp(vecs[i].inst, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
      checkOutput($sformatf("vec%0d_lat", i), 32'(lat), 32'(latencyOf(vecs[i].inst)));
      checkOutput($sformatf("vec%0d_sum", i), 32'(sumArr[vecs[i].inst]), 32'(vecs[i].expSum));
      checkOutput($sformatf("vec%0d_cout", i), 32'(coutV[vecs[i].inst]), 32'(vecs[i].expCout));
      checkOutput($sformatf("vec%0d_ovf", i), 32'(ovfV[vecs[i].inst]), 32'(vecs[i].expOvf));
    end

    // A start two cycles into RUN must be dropped, not queued.
    @(negedge clk);
    applyStimulus(2, 16'h1234, 16'h1111, 1'b0, 1'b0);
    waitAccept();
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 2) applyStimulus(2, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
      else startV = '0;
      if (doneV[2]) break;
    end
    startV = '0;
    checkOutput("ignore_lat", 32'(lat), 32'd4);
    checkOutput("ignore_sum", 32'(sumArr[2]), 32'h2345);
    checkOutput("ignore_cout", 32'(coutV[2]), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("ignore_not_queued", 32'(busyV[2]), 32'h0);

    // Back-to-back: second start issued during the done cycle.
    @(negedge clk);
    applyStimulus(2, 16'hA5A5, 16'h0F0F, 1'b1, 1'b1);
    waitAccept();
    checkOutput("b2b_busy", 32'(busyV[2]), 32'h1);
    waitDone(2, lat);
    model(16'hA5A5, 16'h0F0F, 1'b1, 1'b1, mSum, mCout, mOvf);
    checkOutput("b2b_first_lat", 32'(lat), 32'd4);
    checkOutput("b2b_first_sum", 32'(sumArr[2]), 32'(mSum));
    applyStimulus(2, 16'h4000, 16'h4000, 1'b0, 1'b0);
    waitAccept();
    waitDone(2, lat);
    model(16'h4000, 16'h4000, 1'b0, 1'b0, mSum, mCout, mOvf);
    checkOutput("b2b_second_lat", 32'(lat), 32'd4);
    checkOutput("b2b_second_sum", 32'(sumArr[2]), 32'(mSum));
    checkOutput("b2b_second_ovf", 32'(ovfV[2]), 32'(mOvf));

    // Reset two cycles into RUN aborts the operation.
    @(negedge clk);
    applyStimulus(2, 16'h1111, 16'h2222, 1'b0, 1'b0);
    waitAccept();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abort_busy", 32'(busyV[2]), 32'h0);
    checkOutput("abort_done", 32'(doneV[2]), 32'h0);
    checkOutput("abort_sum", 32'(sumArr[2]), 32'h0);
    checkOutput("abort_cout", 32'(coutV[2]), 32'h0);
    checkOutput("abort_ovf", 32'(ovfV[2]), 32'h0);
    sawDone = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      sawDone = sawDone | doneV[2];
    end
    checkOutput("abort_no_done", 32'(sawDone), 32'h0);
    runOp(2, 16'h1111, 16'h2222, 1'b0, 1'b0, lat);
    checkOutput("abort_after_lat", 32'(lat), 32'd4);
    checkOutput("abort_after_sum", 32'(sumArr[2]), 32'h3333);

    // Randomised sweep over every DIGIT at WIDTH=16.
    for (int inst = 0; inst < 5; inst++) begin
      for (int n = 0; n < 200; n++) begin
        logic [15:0] ra, rb;
        logic        rc, rs;
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom);
        rs = 1'($urandom);
        runOp(inst, ra, rb, rc, rs, lat);
        model(ra, rb, rc, rs, mSum, mCout, mOvf);
        checkOutput($sformatf("rand_d%0d_lat", 1 << inst), 32'(lat), 32'(latencyOf(inst)));
        checkOutput($sformatf("rand_d%0d_sum", 1 << inst), 32'(sumArr[inst]), 32'(mSum));
        checkOutput($sformatf("rand_d%0d_cout", 1 << inst), 32'(coutV[inst]), 32'(mCout));
        checkOutput($sformatf("rand_d%0d_ovf", 1 << inst), 32'(ovfV[inst]), 32'(mOvf));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
